// File: rtl/sysid_regbank.sv
// sysid_regbank
//   System-identification slave on the Avalon-MM control bus. Software reads it
//   first to confirm bitstream identity and build capabilities.
//
//   Word map:
//     0 ID (RO)           1 TIMESTAMP (RO)
//     2 UPTIME_LO (RO)    reading it also latches the high word into hi_shadow
//     3 UPTIME_HI (RO)    returns hi_shadow
//     4 SCRATCH (RW)
//     5 CTRL: [0] run (RW), [1] clear (write-1 pulse, reads 0), [15:8] NUM_FEATURE
//     6..5+NUM_FEATURE    FEATURE[i] (RO)
//     anything else reads 0 and ignores writes
//
//   Ports:
//     clock          system clock
//     reset          asynchronous, active-high reset
//     address        word address
//     read / write   access strobes; write wins if both are asserted
//     writedata      write data
//     byteenable     byte lanes for writes to SCRATCH / CTRL
//     readdata       registered read data, held while readdatavalid is low
//     readdatavalid  one-cycle pulse, one cycle after the read is sampled

module sysid_regbank #(
    parameter logic [31:0]               ID_VALUE      = 32'h0400_0000,
    parameter logic [31:0]               TIMESTAMP     = 32'h5480_6E82,
    parameter int                        NUM_FEATURE   = 2,
    parameter logic [32*NUM_FEATURE-1:0] FEATURE_WORDS = '0,
    parameter int                        ADDR_W        = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    if (NUM_FEATURE < 1 || NUM_FEATURE > 16) begin : g_bad_num_feature
        $error("sysid_regbank: NUM_FEATURE must be in 1..16");
    end
    if ((2 ** ADDR_W) < (6 + NUM_FEATURE)) begin : g_bad_addr_w
        $error("sysid_regbank: ADDR_W too small for the feature words");
    end

    logic [31:0] scratch;
    logic        run;
    logic [63:0] uptime;
    logic [31:0] hi_shadow;

    logic        wr_scratch;
    logic        wr_ctrl;
    logic        clear;
    logic        rd_fire;
    logic [31:0] rd_value;

    assign wr_scratch = write && (address == ADDR_W'(4));
    assign wr_ctrl    = write && (address == ADDR_W'(5));
    // clear lives in byte lane 0, so it only fires when that lane is enabled
    assign clear      = wr_ctrl && byteenable[0] && writedata[1];
    // a simultaneous write takes the cycle; the read is dropped
    assign rd_fire    = read && !write;

    always_comb begin
        rd_value = '0;
        case (address)
            ADDR_W'(0): rd_value = ID_VALUE;
            ADDR_W'(1): rd_value = TIMESTAMP;
            ADDR_W'(2): rd_value = uptime[31:0];
            ADDR_W'(3): rd_value = hi_shadow;
            ADDR_W'(4): rd_value = scratch;
            ADDR_W'(5): rd_value = {16'h0000, 8'(NUM_FEATURE), 7'b0, run};
            default:    rd_value = '0;
        endcase
        for (int i = 0; i < NUM_FEATURE; i++) begin
            if (address == ADDR_W'(6 + i)) begin
                rd_value = FEATURE_WORDS[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= '0;
            run     <= 1'b1;
        end else begin
            if (wr_scratch) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch[8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            if (wr_ctrl && byteenable[0]) begin
                run <= writedata[0];
            end
        end
    end

    // run is sampled before any same-edge CTRL write lands, so a run change
    // takes effect from the following edge; clear always wins over counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uptime <= '0;
        end else if (clear) begin
            uptime <= '0;
        end else if (run) begin
            uptime <= uptime + 64'd1;
        end
    end

    // Reading the low word snapshots the high word at the same edge so the
    // two halves always come from one counter sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            hi_shadow     <= '0;
        end else begin
            readdatavalid <= rd_fire;
            if (rd_fire) begin
                readdata <= rd_value;
                if (address == ADDR_W'(2)) begin
                    hi_shadow <= uptime[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_regbank.sv
// tb_sysid_regbank
//   Directed bench for sysid_regbank. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle clear of the active edge.

module tb_sysid_regbank;

    localparam int          NUM_FEATURE = 2;
    localparam int          ADDR_W      = 4;
    localparam logic [63:0] FEATS       = {32'hCAFE_0001, 32'h0000_BEEF};

    logic        clock;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_checks = 0;
    int n_fail   = 0;

    sysid_regbank #(
        .NUM_FEATURE   (NUM_FEATURE),
        .FEATURE_WORDS (FEATS),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge with strobes idle.
    task automatic do_read(input logic [3:0] a, output logic [31:0] data, output logic vld);
        address = a;
        read    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        data = readdata;
        vld  = readdatavalid;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        do_read(a, d, v);
        check_val({tag, " valid"}, 32'(v), 32'd1);
        check_val(tag, d, exp);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic        v;

        reset      = 1'b1;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        repeat (3) @(negedge clock);
        check_val("reset readdata", readdata, 32'h0);
        check_val("reset valid", 32'(readdatavalid), 32'd0);
        reset = 1'b0;
        idle(1);

        // back-to-back reads of ID, TIMESTAMP, CTRL
        address = 4'd0;
        read    = 1'b1;
        @(posedge clock); @(negedge clock);
        check_val("b2b id valid", 32'(readdatavalid), 32'd1);
        check_val("b2b id", readdata, 32'h0400_0000);
        address = 4'd1;
        @(posedge clock); @(negedge clock);
        check_val("b2b ts valid", 32'(readdatavalid), 32'd1);
        check_val("b2b ts", readdata, 32'h5480_6E82);
        address = 4'd5;
        @(posedge clock); @(negedge clock);
        check_val("b2b ctrl valid", 32'(readdatavalid), 32'd1);
        check_val("b2b ctrl", readdata, 32'h0000_0201);
        read = 1'b0;
        @(posedge clock); @(negedge clock);
        check_val("idle valid", 32'(readdatavalid), 32'd0);
        check_val("idle hold", readdata, 32'h0000_0201);

        // scratch byte lanes, RO write ignored, features, unmapped
        do_write(4'd4, 32'hA5A5_A5A5, 4'b1111);
        do_write(4'd4, 32'h0000_1234, 4'b0011);
        rd_check("scratch lanes", 4'd4, 32'hA5A5_1234);
        do_write(4'd4, 32'h7700_0000, 4'b1000);
        rd_check("scratch lane3", 4'd4, 32'h77A5_1234);
        do_write(4'd0, 32'hDEAD_BEEF, 4'b1111);
        rd_check("id after write", 4'd0, 32'h0400_0000);
        rd_check("feature0", 4'd6, 32'h0000_BEEF);
        rd_check("feature1", 4'd7, 32'hCAFE_0001);
        rd_check("addr 8", 4'd8, 32'h0);
        rd_check("addr 15", 4'd15, 32'h0);
        do_write(4'd15, 32'hFFFF_FFFF, 4'b1111);
        rd_check("scratch after bad write", 4'd4, 32'h77A5_1234);

        // counter advances by one per cycle
        do_read(4'd2, a_val, v);
        do_read(4'd2, b_val, v);
        check_val("uptime step", b_val - a_val, 32'd1);

        // atomic capture across low-word carry
        force dut.uptime = 64'h0000_0000_FFFF_FFFE;
        #1 release dut.uptime;
        rd_check("carry lo", 4'd2, 32'hFFFF_FFFE);
        idle(10);
        rd_check("carry hi shadow", 4'd3, 32'h0);
        rd_check("after carry lo", 4'd2, 32'h0000_000A);
        rd_check("after carry hi", 4'd3, 32'h1);

        // full 64-bit wrap
        @(negedge clock);
        force dut.uptime = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.uptime;
        rd_check("wrap lo", 4'd2, 32'hFFFF_FFFF);
        rd_check("wrap hi", 4'd3, 32'hFFFF_FFFF);
        rd_check("post wrap lo", 4'd2, 32'h1);
        rd_check("post wrap hi", 4'd3, 32'h0);

        // stop, then clear+run
        do_write(4'd5, 32'h0, 4'b1111);
        do_read(4'd2, a_val, v);
        idle(5);
        do_read(4'd2, b_val, v);
        check_val("stopped uptime", b_val, a_val);
        rd_check("ctrl stopped", 4'd5, 32'h0000_0200);
        do_write(4'd5, 32'h3, 4'b0001);
        rd_check("cleared lo", 4'd2, 32'h0);
        rd_check("ctrl running", 4'd5, 32'h0000_0201);
        rd_check("restart lo", 4'd2, 32'h2);

        // read and write together: write wins, no valid
        address    = 4'd4;
        writedata  = 32'h0000_0055;
        byteenable = 4'b1111;
        read       = 1'b1;
        write      = 1'b1;
        @(posedge clock); @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        check_val("rw conflict valid", 32'(readdatavalid), 32'd0);
        rd_check("rw conflict scratch", 4'd4, 32'h0000_0055);

        // reset right after a read is accepted
        do_write(4'd5, 32'h0, 4'b1111);
        address = 4'd0;
        read    = 1'b1;
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check_val("abort valid", 32'(readdatavalid), 32'd0);
        check_val("abort readdata", readdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle(1);
        rd_check("reset scratch", 4'd4, 32'h0);
        rd_check("reset ctrl", 4'd5, 32'h0000_0201);
        rd_check("reset hi shadow", 4'd3, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
